// File: rtl/i2c_master_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_write_sequencer_pkg
// Purpose  : Shared I2C definitions for the master write path.
//            - byte-writer command codes
//            - bit-level command codes
//            - write-sequencer state enum
//            - small helpers mapping sequencer states to byte-writer commands
// Revision : 1.0 - initial release
// ============================================================================
package i2c_master_write_sequencer_pkg;

  // Byte-writer commands
  localparam logic [2:0] c_bw_cmd_idle  = 3'b000;
  localparam logic [2:0] c_bw_cmd_start = 3'b001;
  localparam logic [2:0] c_bw_cmd_data  = 3'b011;
  localparam logic [2:0] c_bw_cmd_ack   = 3'b111;
  localparam logic [2:0] c_bw_cmd_nack  = 3'b101;
  localparam logic [2:0] c_bw_cmd_stop  = 3'b100;

  // Bit-level commands used by the bit engine below the byte writer
  localparam logic [2:0] c_bit_cmd_idle  = 3'b000;
  localparam logic [2:0] c_bit_cmd_start = 3'b001;
  localparam logic [2:0] c_bit_cmd_stop  = 3'b010;
  localparam logic [2:0] c_bit_cmd_write = 3'b011;
  localparam logic [2:0] c_bit_cmd_read  = 3'b100;

  // Write-sequencer states
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_FETCH    = 4'd4,
    ST_DATA     = 4'd5,
    ST_DATA_ACK = 4'd6,
    ST_STOP     = 4'd7,
    ST_DONE     = 4'd8
  } seq_state_t;

  // States in which the byte writer is being driven
  function automatic logic is_bw_state(input seq_state_t s);
    return (s == ST_START) || (s == ST_ADDR) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

  // States in which the slave ACK bit is being sampled
  function automatic logic is_ack_state(input seq_state_t s);
    return (s == ST_ADDR_ACK) || (s == ST_DATA_ACK);
  endfunction

  // Byte-writer command associated with a sequencer state
  function automatic logic [2:0] bw_cmd_for(input seq_state_t s);
    logic [2:0] cmd;
    cmd = c_bw_cmd_idle;
    case (s)
      ST_START:        cmd = c_bw_cmd_start;
      ST_ADDR, ST_DATA: cmd = c_bw_cmd_data;
      ST_STOP:         cmd = c_bw_cmd_stop;
      default:         cmd = c_bw_cmd_idle;
    endcase
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_master_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_write_sequencer_if
// Purpose  : Bundles the write sequencer's request, data-stream, status,
//            byte-writer and read-bit signals.
// Ports    : none (signal container)
//            modport master - the sequencer side
//            modport slave  - the host / byte-writer / read-bit side
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_master_write_sequencer_if #(
  parameter int LEN_W = 8
);

  // Request handshake
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_addr;
  logic [LEN_W-1:0] req_len;

  // Data byte stream
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;

  // Status
  logic             busy;
  logic             done;
  logic             nack_err;
  logic [LEN_W-1:0] nack_idx;

  // Byte writer
  logic             bw_go;
  logic [2:0]       bw_command;
  logic             bw_data;
  logic             bw_load;
  logic             bw_finish;

  // Read-bit block (slave ACK)
  logic             ack_go;
  logic             ack_finish;
  logic             ack_sda;

  modport master (
    input  req_valid, req_addr, req_len,
    input  wr_valid, wr_data,
    input  bw_load, bw_finish,
    input  ack_finish, ack_sda,
    output req_ready, wr_ready,
    output busy, done, nack_err, nack_idx,
    output bw_go, bw_command, bw_data,
    output ack_go
  );

  modport slave (
    output req_valid, req_addr, req_len,
    output wr_valid, wr_data,
    output bw_load, bw_finish,
    output ack_finish, ack_sda,
    input  req_ready, wr_ready,
    input  busy, done, nack_err, nack_idx,
    input  bw_go, bw_command, bw_data,
    input  ack_go
  );

endinterface
`default_nettype wire

// File: rtl/i2c_master_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_write_sequencer
// Purpose  : Transaction controller for the I2C master write path. Sequences
//            START, the address byte, each data byte (with a slave ACK sample
//            after every byte) and STOP through an external byte writer, one
//            bit at a time from an internal shift register.
// Ports    : clock  - single clock, rising edge
//            reset  - synchronous, active-high
//            bus    - i2c_master_write_sequencer_if.master
//                     (request, data stream, status, byte writer, read-bit)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_write_sequencer
  import i2c_master_write_sequencer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  wire logic                           clock,
  input  wire logic                           reset,
  i2c_master_write_sequencer_if.master        bus
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;

  logic [7:0]       r_shreg;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_idx;
  logic             r_nack_err;
  logic [LEN_W-1:0] r_nack_idx;
  logic             r_bw_go;
  logic [2:0]       r_bw_command;
  logic             r_bw_data;
  logic             r_ack_go;

  logic             w_bw_state;
  logic             w_ack_state;
  logic             w_bw_go_nxt;
  logic             w_ack_go_nxt;

  assign w_bw_state  = is_bw_state(r_state);
  assign w_ack_state = is_ack_state(r_state);

  // go drops in the cycle after finish is seen; since finish also moves the
  // state, the next command state starts with go low, which re-arms the
  // byte writer between commands.
  assign w_bw_go_nxt  = w_bw_state && !bus.bw_finish;
  assign w_ack_go_nxt = w_ack_state && !bus.ack_finish;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (bus.req_valid)  w_state_nxt = ST_START;
      ST_START:    if (bus.bw_finish)  w_state_nxt = ST_ADDR;
      ST_ADDR:     if (bus.bw_finish)  w_state_nxt = ST_ADDR_ACK;
      ST_DATA:     if (bus.bw_finish)  w_state_nxt = ST_DATA_ACK;
      ST_ADDR_ACK,
      ST_DATA_ACK: begin
        if (bus.ack_finish) begin
          if (bus.ack_sda || (r_remaining == '0)) w_state_nxt = ST_STOP;
          else                                    w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH:    if (bus.wr_valid)   w_state_nxt = ST_DATA;
      ST_STOP:     if (bus.bw_finish)  w_state_nxt = ST_DONE;
      ST_DONE:                         w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_remaining  <= '0;
      r_idx        <= '0;
      r_nack_err   <= 1'b0;
      r_nack_idx   <= '0;
      r_bw_go      <= 1'b0;
      r_bw_command <= c_bw_cmd_idle;
      r_bw_data    <= 1'b0;
      r_ack_go     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bw_go      <= w_bw_go_nxt;
      r_bw_command <= w_bw_go_nxt ? bw_cmd_for(r_state) : c_bw_cmd_idle;
      r_ack_go     <= w_ack_go_nxt;

      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_remaining <= bus.req_len;
            r_idx       <= '0;
            r_shreg     <= {bus.req_addr, 1'b0};
            r_nack_err  <= 1'b0;
            r_nack_idx  <= '0;
          end
        end

        // bw_data is a registered copy of shreg[7]; it only moves on entry
        // to ADDR/DATA or on a load, so it is stable while the writer holds
        // the bit.
        ST_START: begin
          if (bus.bw_finish) r_bw_data <= r_shreg[7];
        end

        ST_ADDR, ST_DATA: begin
          // A load coinciding with finish still shifts; the state advance
          // happens in the same edge through w_state_nxt.
          if (bus.bw_load) begin
            r_shreg   <= {r_shreg[6:0], 1'b0};
            r_bw_data <= r_shreg[6];
          end
        end

        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (bus.ack_finish && bus.ack_sda) begin
            r_nack_err <= 1'b1;
            r_nack_idx <= r_idx;
          end
        end

        ST_FETCH: begin
          if (bus.wr_valid) begin
            r_shreg   <= bus.wr_data;
            r_bw_data <= bus.wr_data[7];
            r_idx     <= r_idx + LEN_W'(1);
            if (r_remaining != '0) r_remaining <= r_remaining - LEN_W'(1);
          end
        end

        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.wr_ready   = (r_state == ST_FETCH);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.nack_err   = r_nack_err;
  assign bus.nack_idx   = r_nack_idx;
  assign bus.bw_go      = r_bw_go;
  assign bus.bw_command = r_bw_command;
  assign bus.bw_data    = r_bw_data;
  assign bus.ack_go     = r_ack_go;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_write_sequencer
// Purpose  : Self-checking bench for i2c_master_write_sequencer. Behavioural
//            byte-writer, read-bit and data-source models drive the DUT; a
//            transaction-level model predicts the bus event sequence, the
//            number of fetched bytes, ACK samples and the error report.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_write_sequencer;

  localparam int LEN_W   = 8;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 257;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  i2c_master_write_sequencer_if #(.LEN_W(LEN_W)) bus ();

  i2c_master_write_sequencer #(.LEN_W(LEN_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Environment state shared by the responder process and the main sequence
  int         obs_q[$];
  logic [7:0] src_q[$];
  int         nack_at      = -1;
  int         ack_count    = 0;
  int         fetch_count  = 0;
  bit         wr_ready_seen = 0;
  int         hold_left    = 0;
  bit         hold_started = 0;

  // Byte-writer model state
  bit         rb_active = 0;
  bit         rb_armed  = 0;
  bit         rb_fin_pend = 0;
  logic [2:0] rb_cmd    = 3'b000;
  int         rb_bit    = 0;
  int         rb_wait   = 0;
  logic [7:0] rb_byte   = 8'h00;

  // Read-bit model state
  bit         ra_active = 0;
  bit         ra_armed  = 0;
  int         ra_wait   = 0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = 7'h00;
    bus.req_len    = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;
    bus.bw_load    = 1'b0;
    bus.bw_finish  = 1'b0;
    bus.ack_finish = 1'b0;
    bus.ack_sda    = 1'b0;
  end

  task automatic rb_finish();
    bus.bw_finish = 1'b1;
    check_eq("bw_cmd_stable", {29'd0, bus.bw_command}, {29'd0, rb_cmd});
    case (rb_cmd)
      3'b001:  obs_q.push_back(EV_START);
      3'b100:  obs_q.push_back(EV_STOP);
      3'b011:  obs_q.push_back(int'(rb_byte));
      default: obs_q.push_back(512 + int'(rb_cmd));
    endcase
    rb_active = 0;
    rb_armed  = 0;
  endtask

  // Byte writer, read-bit block and data source, stepped once per cycle
  initial begin
    forever begin
      @(posedge clock);
      #1;
      bus.bw_load    = 1'b0;
      bus.bw_finish  = 1'b0;
      bus.ack_finish = 1'b0;
      bus.ack_sda    = 1'b0;
      if (reset) begin
        rb_active   = 0;
        rb_armed    = 0;
        rb_fin_pend = 0;
        ra_active   = 0;
        ra_armed    = 0;
        bus.wr_valid = 1'b0;
        src_q.delete();
      end else begin
        // byte writer
        if (!bus.bw_go) rb_armed = 1;
        if (!rb_active && bus.bw_go && rb_armed) begin
          rb_active   = 1;
          rb_cmd      = bus.bw_command;
          rb_bit      = 0;
          rb_byte     = 8'h00;
          rb_fin_pend = 0;
          rb_wait     = $urandom_range(1, 3);
        end else if (rb_active) begin
          rb_wait--;
          if (rb_wait == 0) begin
            if (rb_cmd == 3'b011 && !rb_fin_pend) begin
              rb_byte = {rb_byte[6:0], bus.bw_data};
              rb_bit++;
              bus.bw_load = 1'b1;
              if (rb_bit == 8) begin
                if ($urandom_range(0, 1) == 1) rb_finish();
                else begin
                  rb_fin_pend = 1;
                  rb_wait     = $urandom_range(1, 2);
                end
              end else begin
                rb_wait = $urandom_range(1, 3);
              end
            end else begin
              rb_finish();
            end
          end
        end

        // read-bit block (slave ACK)
        if (!bus.ack_go) ra_armed = 1;
        if (!ra_active && bus.ack_go && ra_armed) begin
          ra_active = 1;
          ra_wait   = $urandom_range(1, 3);
        end else if (ra_active) begin
          ra_wait--;
          if (ra_wait == 0) begin
            bus.ack_finish = 1'b1;
            bus.ack_sda    = (ack_count == nack_at);
            ack_count++;
            ra_active = 0;
            ra_armed  = 0;
          end
        end

        // data source
        if (bus.wr_ready) wr_ready_seen = 1;
        if (hold_left > 0 && (hold_started || bus.wr_ready)) begin
          hold_started = 1;
          check_eq("hold_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
          check_eq("hold_bw_go", {31'd0, bus.bw_go}, 32'd0);
          hold_left--;
          bus.wr_valid = 1'b0;
        end else begin
          bus.wr_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
          if (bus.wr_valid) bus.wr_data = src_q[0];
          if (bus.wr_valid && bus.wr_ready) begin
            void'(src_q.pop_front());
            fetch_count++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [6:0] addr, input int len);
    int t;
    bus.req_addr  = addr;
    bus.req_len   = LEN_W'(len);
    bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      tick();
      t++;
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [6:0] addr, input int len, input int nack,
                         input int hold, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] data[$];
    int         exp_ev[$];
    bit         exp_err;
    int         exp_fetch;
    int         t;
    int         n;

    data.delete();
    for (int i = 0; i < len; i++) begin
      if (i == 0)      data.push_back(d0);
      else if (i == 1) data.push_back(d1);
      else             data.push_back(8'($urandom));
    end

    // Transaction-level expectation
    exp_ev.delete();
    exp_ev.push_back(EV_START);
    exp_ev.push_back(int'(addr) * 2);
    for (int k = 1; k <= len; k++) begin
      if (nack >= 0 && nack < k) break;
      exp_ev.push_back(int'(data[k-1]));
    end
    exp_ev.push_back(EV_STOP);
    exp_err   = (nack >= 0) && (nack <= len);
    exp_fetch = exp_err ? nack : len;

    obs_q.delete();
    src_q.delete();
    foreach (data[i]) src_q.push_back(data[i]);
    ack_count     = 0;
    fetch_count   = 0;
    nack_at       = nack;
    wr_ready_seen = 0;
    hold_left     = hold;
    hold_started  = 0;

    send_req(addr, len);
    check_eq("accept_busy", {31'd0, bus.busy}, 32'd1);
    check_eq("accept_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_eq("accept_bw_go", {31'd0, bus.bw_go}, 32'd0);
    tick();
    check_eq("first_bw_go", {31'd0, bus.bw_go}, 32'd1);
    check_eq("first_bw_cmd", {29'd0, bus.bw_command}, 32'd1);

    t = 0;
    while (!bus.done && t < 20000) begin
      tick();
      t++;
    end
    check_eq("done_seen", {31'd0, bus.done}, 32'd1);
    check_eq("done_busy", {31'd0, bus.busy}, 32'd1);
    check_eq("nack_err", {31'd0, bus.nack_err}, {31'd0, exp_err});
    if (exp_err) check_eq("nack_idx", {24'd0, bus.nack_idx}, 32'(nack));

    tick();
    check_eq("post_done", {31'd0, bus.done}, 32'd0);
    check_eq("post_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("post_req_ready", {31'd0, bus.req_ready}, 32'd1);

    check_eq("fetch_count", 32'(fetch_count), 32'(exp_fetch));
    check_eq("ack_count", 32'(ack_count), 32'(exp_err ? nack + 1 : len + 1));
    if (len == 0) check_eq("wr_ready_probe", {31'd0, wr_ready_seen}, 32'd0);

    check_eq("event_count", 32'(obs_q.size()), 32'(exp_ev.size()));
    n = (obs_q.size() < exp_ev.size()) ? obs_q.size() : exp_ev.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("event[%0d]", i), 32'(obs_q[i]), 32'(exp_ev[i]));

    src_q.delete();
    hold_left = 0;
  endtask

  initial begin
    int t;
    int len;
    int nack;
    bit hit;

    repeat (3) tick();
    check_eq("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    check_eq("rst_bw_go", {31'd0, bus.bw_go}, 32'd0);
    check_eq("rst_bw_cmd", {29'd0, bus.bw_command}, 32'd0);
    check_eq("rst_bw_data", {31'd0, bus.bw_data}, 32'd0);
    check_eq("rst_ack_go", {31'd0, bus.ack_go}, 32'd0);
    check_eq("rst_nack_err", {31'd0, bus.nack_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed scenarios
    run_txn(7'h50, 2, -1, 0, 8'hA5, 8'h3C);
    run_txn(7'h2A, 0, -1, 0, 8'h00, 8'h00);
    run_txn(7'h11, 3, 2, 0, 8'h5A, 8'hC3);
    run_txn(7'h7F, 2, 0, 0, 8'hFF, 8'h01);
    run_txn(7'h33, 2, -1, 20, 8'h81, 8'h7E);

    // Reset during the 4th bit of the first data byte
    src_q.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
    obs_q.delete();
    ack_count = 0;
    nack_at   = -1;
    send_req(7'h45, 3);
    t   = 0;
    hit = 0;
    while (!hit && t < 2000) begin
      tick();
      t++;
      hit = rb_active && (rb_cmd == 3'b011) && (obs_q.size() >= 2) && (rb_bit == 3);
    end
    check_eq("reset_point", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check_eq("midrst_bw_go", {31'd0, bus.bw_go}, 32'd0);
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    check_eq("midrst_ack_go", {31'd0, bus.ack_go}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_txn(7'h45, 2, -1, 0, 8'($urandom), 8'($urandom));

    // Longest request the count field allows
    run_txn(7'($urandom), (1 << LEN_W) - 1, -1, 0, 8'($urandom), 8'($urandom));

    // Randomized requests
    for (int r = 0; r < 12; r++) begin
      len  = $urandom_range(0, 5);
      nack = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
      run_txn(7'($urandom), len, nack, 0, 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_write_sequencer.md
# i2c_master_write_sequencer

Transaction-level controller for the I2C master write path. It takes one write request (7-bit slave address plus a byte count) and sequences the byte writer through START, the address byte, each data byte, a slave-ACK sample after every byte, and STOP. It feeds the byte writer one bit at a time from an internal shift register and pulls data bytes from an upstream stream. It sits between the host-side register/FIFO logic and `I2C_master_write_byte` plus the master read-bit block.

## Interface
- `LEN_W`, default 8: width of the byte-count field; a request carries at most 2^LEN_W−1 data bytes.
- `clock` in, 1: single clock; every register updates on its rising edge.
- `reset` in, 1: synchronous, active-high.
- `req_valid` in, 1 / `req_ready` out, 1: request handshake. The request is accepted in the cycle both are high.
- `req_addr` in, 7: slave address.
- `req_len` in, LEN_W: number of data bytes; 0 means address-only probe.
- `wr_valid` in, 1 / `wr_ready` out, 1 / `wr_data` in, 8: data byte stream. One byte is accepted per data phase.
- `busy` out, 1: high from request acceptance until the `done` pulse, inclusive.
- `done` out, 1: one-cycle pulse at the end of a transaction.
- `nack_err` out, 1: valid with `done`. 1 means the slave NACKed.
- `nack_idx` out, LEN_W: valid with `done` when `nack_err`=1. 0 = address byte; k = k-th data byte.
- `bw_go` out, 1 / `bw_command` out, 3 / `bw_data` out, 1: drive the byte writer.
- `bw_load` in, 1 / `bw_finish` in, 1: inputs from the byte writer.
- `ack_go` out, 1 / `ack_finish` in, 1 / `ack_sda` in, 1: drive the read-bit block for the slave ACK. `ack_sda`=0 is ACK and is valid when `ack_finish`=1.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, FETCH, DATA, DATA_ACK, STOP, DONE.
- Byte-writer commands: START=3'b001, DATA=3'b011, STOP=3'b100. Unused: ACK=3'b111, NACK=3'b101, IDLE=3'b000.
- IDLE:
  - `req_ready`=1.
  - On accept: latch `req_len` into `remaining`, load `shreg` ← {req_addr,1'b0}, clear the error flags, go to START.
- START: issue START. On `bw_finish` go to ADDR.
- ADDR and DATA: issue DATA with `bw_data`=`shreg[7]`. On `bw_load`, `shreg` shifts left by one. On `bw_finish` go to ADDR_ACK or DATA_ACK.
- ADDR_ACK and DATA_ACK: assert `ack_go`. On `ack_finish`:
  - `ack_sda`=1: record `nack_idx`, set the error flag, go to STOP.
  - `ack_sda`=0 and `remaining`=0: go to STOP.
  - otherwise: go to FETCH.
- FETCH:
  - `wr_ready`=1.
  - On `wr_valid`: `shreg`←`wr_data`, `remaining`−1, data index+1, go to DATA.
  - Waits indefinitely; SCL stays held by the byte writer's idle level.
- STOP: issue STOP. On `bw_finish` go to DONE.
- DONE: `done`=1 for one cycle, go to IDLE.
- Counters:
  - `remaining` and the data index are LEN_W wide.
  - `remaining` never decrements below 0.
  - The index never wraps, because `req_len` ≤ 2^LEN_W−1.

## Timing
- Reset: state IDLE. All outputs 0 except `req_ready`=1. `shreg` and the counters are 0.
- Reset mid-transaction: the next edge forces IDLE and reset values. No STOP is issued; the bus must be recovered by the byte-writer reset.
- `bw_go`, `bw_command` and `ack_go` are registered:
  - They assert the cycle after entering a command state.
  - They deassert in the cycle after `bw_finish`/`ack_finish` is seen.
  - `bw_go` is low for at least one cycle between consecutive commands, so the byte writer re-arms.
- `bw_command` is stable while `bw_go`=1. `bw_data` changes only on `bw_load` or on entry to ADDR/DATA.
- Simultaneous `bw_load` and `bw_finish`: the shift happens, then the state advances.
- A request presented while busy is not accepted (`req_ready`=0). `wr_ready` is never high outside FETCH.
- Latency from accept to first `bw_go`: 1 cycle.

## Structure
- The shared I2C package holds:
  - byte-writer command constants (IDLE/START/DATA/ACK/NACK/STOP);
  - bit-command constants;
  - the sequencer state enum.
- No sub-module. `shreg` is inline.
- The byte writer and read-bit block are instantiated by the parent, not here.

## Test plan
- Request addr 7'h50, len 2, data 8'hA5, 8'h3C, slave ACKs all → START, bits 1010_0000, 1010_0101, 0011_1100, STOP; `done` with `nack_err`=0.
- Request addr 7'h2A, len 0, ACK → START, address byte 0101_0100, STOP, `done`. `wr_ready` never asserts.
- Request len 3, slave NACKs the 2nd data byte → STOP after byte 2; `done`, `nack_err`=1, `nack_idx`=2. The 3rd byte is not fetched.
- Address NACK → STOP immediately; `nack_idx`=0.
- `wr_valid` withheld 20 cycles in FETCH → no bw_go activity, `wr_ready` held; the transaction resumes on `wr_valid`.
- `reset` asserted during the 4th bit of a data byte → the next cycle is IDLE, `req_ready`=1, `bw_go`=0, `busy`=0. A new request then completes normally.
